shift_arbiter: RTL and testbench

Round-robin arbiter that shares one registered 8-bit barrel shifter among N_REQ requesters. Each requester has a valid/ready request channel and a valid/ready response channel. The block issues at most one shift per cycle, tracks the requester tag through the shifter's 1-cycle latency, and parks each result in a per-requester response slot until the requester takes it. It sits between the execution-side requesters and the single shifter instance; both use the same clk/rst.

---
 rtl/shift_arbiter.sv | 140 ++++++++++++++
 tb/tb_shift_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit barrel shifter among N_REQ
// requesters, with per-requester response slots.
// Optional build macro: SHIFT_ARB_STATS_EN adds saturating per-requester grant
// counters (stat_clr / stat_grant_cnt ports).
module shift_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*8-1:0]   req_data,
    input  logic [N_REQ*3-1:0]   req_shamt,
    input  logic [N_REQ-1:0]     req_dir,
    input  logic [N_REQ-1:0]     req_arith,
    output logic [N_REQ-1:0]     resp_valid,
    input  logic [N_REQ-1:0]     resp_ready,
    output logic [N_REQ*8-1:0]   resp_data,
    output logic [7:0]           sh_in_1,
    output logic [2:0]           sh_shamt,
    output logic                 sh_L_R,
    output logic                 sh_A_L,
    output logic                 sh_in_valid,
    input  logic [7:0]           sh_out_1,
    input  logic                 sh_out_valid
`ifdef SHIFT_ARB_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [N_REQ*16-1:0]  stat_grant_cnt
`endif
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SH_W   = 3;
    localparam int unsigned TAG_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] tag_q;
    logic             tag_v_q;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [TAG_W-1:0] grant_idx;
    logic             found;

    function automatic logic [TAG_W-1:0] wrap_idx(input int unsigned v);
        return TAG_W'(v % N_REQ);
    endfunction

    // A requester may issue only with its slot empty and no op in the shifter.
    assign eligible = req_valid & ~resp_valid & ~grant_q & {N_REQ{~rst}};

    // Round-robin search starting at rr_ptr.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && eligible[wrap_idx(32'(rr_ptr) + k)]) begin
                found     = 1'b1;
                grant_idx = wrap_idx(32'(rr_ptr) + k);
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant;

    // Steer the granted requester's operands onto the shifter; idle drives zero.
    always_comb begin
        sh_in_valid = found;
        sh_in_1     = '0;
        sh_shamt    = '0;
        sh_L_R      = 1'b0;
        sh_A_L      = 1'b0;
        if (found) begin
            sh_in_1  = req_data[32'(grant_idx)*DATA_W +: DATA_W];
            sh_shamt = req_shamt[32'(grant_idx)*SH_W +: SH_W];
            sh_L_R   = req_dir[grant_idx];
            sh_A_L   = req_arith[grant_idx];
        end
    end

    // Pointer advance and tag pipeline matching the shifter's one-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            tag_q   <= '0;
            tag_v_q <= 1'b0;
            grant_q <= '0;
        end else begin
            tag_q   <= grant_idx;
            tag_v_q <= found;
            grant_q <= grant;
            if (found) begin
                rr_ptr <= wrap_idx(32'(grant_idx) + 32'd1);
            end
        end
    end

    // Response slots: drain on handshake, fill from the tagged shifter result.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    resp_valid[i] <= 1'b0;
                end
            end
            if (sh_out_valid && tag_v_q) begin
                resp_valid[tag_q]                       <= 1'b1;
                resp_data[32'(tag_q)*DATA_W +: DATA_W]  <= sh_out_1;
            end
        end
    end

    // A shifter result with no tag in flight indicates a broken shifter hookup.
    a_no_orphan_result: assert property (@(posedge clk) disable iff (rst)
        sh_out_valid |-> tag_v_q);

`ifdef SHIFT_ARB_STATS_EN
    // Saturating per-requester grant counters; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_grant_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (grant[i] && stat_grant_cnt[i*16 +: 16] != 16'hFFFF) begin
                    stat_grant_cnt[i*16 +: 16] <= stat_grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a response scoreboard and a behavioural
// registered shifter attached to the sh_* ports.
module tb_shift_arbiter;

    localparam int N = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*8-1:0]  req_data;
    logic [N*3-1:0]  req_shamt;
    logic [N-1:0]    req_dir;
    logic [N-1:0]    req_arith;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [N*8-1:0]  resp_data;
    logic [7:0]      sh_in_1;
    logic [2:0]      sh_shamt;
    logic            sh_L_R;
    logic            sh_A_L;
    logic            sh_in_valid;
    logic [7:0]      sh_out_1;
    logic            sh_out_valid;
`ifdef SHIFT_ARB_STATS_EN
    logic            stat_clr;
    logic [N*16-1:0] stat_grant_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q [N][$];

    shift_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_shamt(req_shamt), .req_dir(req_dir), .req_arith(req_arith),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .sh_in_1(sh_in_1), .sh_shamt(sh_shamt), .sh_L_R(sh_L_R), .sh_A_L(sh_A_L),
        .sh_in_valid(sh_in_valid), .sh_out_1(sh_out_1), .sh_out_valid(sh_out_valid)
`ifdef SHIFT_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_grant_cnt(stat_grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] shf(input logic [7:0] d, input logic [2:0] s,
                                       input logic l, input logic a);
        if (l)      return d << s;
        else if (a) return 8'($signed(d) >>> s);
        else        return d >> s;
    endfunction

    // Behavioural shifter: one registered stage, reset with the arbiter.
    always @(posedge clk) begin
        if (rst) begin
            sh_out_valid <= 1'b0;
            sh_out_1     <= 8'h00;
        end else begin
            sh_out_valid <= sh_in_valid;
            sh_out_1     <= shf(sh_in_1, sh_shamt, sh_L_R, sh_A_L);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every accepted response is compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check($sformatf("unexpected_resp%0d", i), 32'(resp_data[i*8 +: 8]), 32'hDEAD);
                    end else begin
                        check($sformatf("resp_data%0d", i), 32'(resp_data[i*8 +: 8]),
                              32'(exp_q[i].pop_front()));
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [7:0] d, input logic [2:0] s,
                          input logic dir, input logic ar);
        req_data[i*8 +: 8]  = d;
        req_shamt[i*3 +: 3] = s;
        req_dir[i]          = dir;
        req_arith[i]        = ar;
    endtask

    task automatic wait_grant(input int i);
        int n = 0;
        @(negedge clk);
        while (!req_ready[i] && n < 20) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("grant%0d", i), 32'(req_ready[i]), 32'd1);
    endtask

    // Issue one request, wait for its grant, then drop valid after the edge.
    task automatic do_req(input int i, input logic [7:0] d, input logic [2:0] s,
                          input logic dir, input logic ar, input logic [7:0] e);
        set_op(i, d, s, dir, ar);
        req_valid[i] = 1'b1;
        exp_q[i].push_back(e);
        wait_grant(i);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic check_drained(input string name);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check(name, 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 32'd0);
    endtask

    localparam logic [7:0] FAIR_EXP [4] = '{8'h22, 8'h44, 8'h66, 8'h88};

    initial begin
        clk = 1'b0; rst = 1'b1;
        req_valid = '0; req_data = '0; req_shamt = '0; req_dir = '0; req_arith = '0;
        resp_ready = '1;
`ifdef SHIFT_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        apply_reset();

        // Reset state
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_sh_in_valid", 32'(sh_in_valid), 32'd0);
        check("rst_sh_in_1", 32'(sh_in_1), 32'd0);

        // 1: single requests with latency check
        @(posedge clk); #1;
        do_req(0, 8'h96, 3'd2, 1'b0, 1'b1, 8'hE5);
        @(negedge clk);
        check("lat_t1_resp_valid0", 32'(resp_valid[0]), 32'd0);
        @(negedge clk);
        check("lat_t2_resp_valid0", 32'(resp_valid[0]), 32'd1);
        @(posedge clk); #1;
        do_req(0, 8'h96, 3'd2, 1'b0, 1'b0, 8'h25);
        do_req(0, 8'h96, 3'd3, 1'b1, 1'b0, 8'hB0);
        check_drained("t1_drained");

        // 2: fairness with all requesters continuously valid
        apply_reset();
        for (int i = 0; i < N; i++) set_op(i, 8'(8'h11 * (i + 1)), 3'd1, 1'b1, 1'b0);
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("fair_grant_c%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            exp_q[k % 4].push_back(FAIR_EXP[k % 4]);
        end
        @(posedge clk); #1;
        req_valid = '0;
        check_drained("t2_drained");

        // 3: backpressure on slot 1
        apply_reset();
        @(posedge clk); #1;
        resp_ready[1] = 1'b0;
        do_req(1, 8'h01, 3'd0, 1'b0, 1'b0, 8'h01);
        set_op(1, 8'h80, 3'd7, 1'b0, 1'b1);
        req_valid[1] = 1'b1;
        exp_q[1].push_back(8'hFF);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_resp_valid1", 32'(resp_valid[1]), 32'd1);
            check("bp_resp_data1", 32'(resp_data[15:8]), 32'h01);
            check("bp_req_ready1", 32'(req_ready[1]), 32'd0);
        end
        @(posedge clk); #1;
        resp_ready[1] = 1'b1;
        @(negedge clk);
        check("bp_release_same_cycle", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        check("bp_regrant", 32'(req_ready[1]), 32'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check_drained("t3_drained");

        // 4: reset in the cycle after a grant drops the op
        apply_reset();
        @(posedge clk); #1;
        set_op(0, 8'h0F, 3'd1, 1'b1, 1'b0);
        req_valid[0] = 1'b1;
        wait_grant(0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_sh_in_valid", 32'(sh_in_valid), 32'd0);
        check("mid_rst_resp_data", resp_data, 32'd0);
        @(negedge clk);
        check("mid_rst_no_resp", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        set_op(0, 8'h0F, 3'd1, 1'b1, 1'b0);
        set_op(2, 8'hC3, 3'd1, 1'b0, 1'b1);
        req_valid = 4'b0101;
        exp_q[0].push_back(8'h1E);
        exp_q[2].push_back(8'hE1);
        @(negedge clk);
        check("post_rst_first_winner", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("post_rst_second_winner", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        check_drained("t4_drained");

        // 5: fill slot 2 while slot 0 drains
        apply_reset();
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        do_req(0, 8'h96, 3'd2, 1'b0, 1'b0, 8'h25);
        @(negedge clk);
        @(negedge clk);
        check("sim_slot0_full", 32'(resp_valid[0]), 32'd1);
        @(posedge clk); #1;
        set_op(2, 8'h81, 3'd1, 1'b1, 1'b0);
        req_valid[2] = 1'b1;
        exp_q[2].push_back(8'h02);
        @(negedge clk);
        check("sim_grant2", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        resp_ready[0] = 1'b1;
        @(negedge clk);
        check("sim_before", 32'(resp_valid[2:0]), 32'b001);
        @(negedge clk);
        check("sim_after", 32'(resp_valid[2:0]), 32'b100);
        check_drained("t5_drained");

`ifdef SHIFT_ARB_STATS_EN
        // 6: grant counters count and clear
        apply_reset();
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) do_req(3, 8'h01, 3'd1, 1'b1, 1'b0, 8'h02);
        check_drained("t6_drained");
        check("stat_cnt3", 32'(stat_grant_cnt[63:48]), 32'd5);
        check("stat_cnt0", 32'(stat_grant_cnt[15:0]), 32'd0);
        @(posedge clk); #1;
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        @(negedge clk);
        check("stat_cleared", 32'(stat_grant_cnt[63:48]), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
